fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch front end for the single-issue WISC-SP13 core.
- Keeps the PC, issues one-outstanding-request reads to instruction memory, and hands 16-bit instructions, their PC and PC+2 to the decode/control stage over a valid/ready handshake.
- Takes branch/jump redirects from execute, squashing wrong-path fetches.
- Stops fetching once a HALT (opcode 5'b00000) has been accepted by decode.

Parameters:
- RESET_PC, 16'h0000, first fetch address after reset.
- NOP_INSTR, 16'h0800, value driven on dec_instr when dec_valid=0.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- imem_req  out  1  read request; combinational from state/dec_valid/dec_ready; held high until the imem_ack cycle inclusive.
- imem_addr  out  16  fetch address; registered; stable while imem_req=1.
- imem_ack  in  1  imem_rdata valid this cycle; may arrive in the first imem_req cycle or any later cycle.
- imem_rdata  in  16  instruction word.
- redirect_valid  in  1  execute-stage redirect; squashes every younger fetch.
- redirect_pc  in  16  redirect target.
- dec_valid  out  1  instruction presented to decode.
- dec_ready  in  1  decode accepts when dec_valid && dec_ready.
- dec_instr  out  16  instruction word.
- dec_pc  out  16  address of dec_instr.
- dec_pc_inc  out  16  dec_pc+2, modulo 2^16.
- halted  out  1  HALT accepted; fetch stopped until rst.

Behaviour:
- Reset values: state=IDLE, pc=RESET_PC, imem_addr=RESET_PC, dec_valid=0, dec_instr=NOP_INSTR, dec_pc=0, dec_pc_inc=0, halted=0, imem_req=0. rst wins over every other input in any state, including mid-request; any later imem_ack for the squashed request is ignored.
- IDLE: occupies exactly one cycle after rst deasserts, then goes to FETCH.
- FETCH:
  - imem_req = !dec_valid || dec_ready, with imem_addr=pc.
  - Output register is always empty when an ack arrives.
  - On ack with no redirect: dec_instr<=imem_rdata, dec_pc<=pc, dec_pc_inc<=pc+2, dec_valid<=1, pc<=pc+2, imem_addr<=pc+2.
  - If imem_rdata[15:11]==5'b00000, go to HALTWAIT.
  - Best case: ack in the req cycle gives dec_valid the next cycle and a sustained 1 instr/cycle.
- Output register: holds its value while dec_valid && !dec_ready. On acceptance, dec_valid<=0 unless refilled in the same cycle.
- Redirect (any state except HALT):
  - dec_valid<=0; pc and imem_addr<=redirect_pc.
  - An ack in the same cycle is discarded.
  - If a request is outstanding without an ack this cycle, go to DRAIN; otherwise go to FETCH.
  - A redirect in the same cycle as decode accepting a HALT squashes the HALT: no halt, FETCH at redirect_pc.
- DRAIN:
  - imem_req=1, imem_addr = the old outstanding address; the register update is deferred, with the target kept in pc.
  - On ack: discard data, imem_addr<=pc, go to FETCH.
  - Further redirects overwrite pc; the newest redirect wins.
- HALTWAIT:
  - imem_req=0; HALT held on the outputs.
  - On acceptance: halted<=1, dec_valid<=0, go to HALT.
  - Redirect returns to FETCH.
- HALT: terminal until rst. imem_req=0, dec_valid=0, redirects ignored.
- PC arithmetic: 16-bit wrap; 16'hFFFE+2 = 16'h0000.

Test Plan:
- Reset, imem_ack tied to imem_req, dec_ready=1, memory 0x0000..0x0004 = 0x4001, 0x4202, 0x0000 -> req at 0x0000 the cycle after IDLE; dec_valid for 3 consecutive cycles with dec_pc 0,2,4 and dec_pc_inc 2,4,6; halted=1 the cycle after 0x0000 is accepted; imem_req stays 0.
- 3-cycle ack latency, dec_ready=0 for 4 cycles after the first instr -> dec_instr/dec_pc stable; no new imem_req until dec_ready=1.
- Redirect to 0x0100 while a req to 0x0006 is outstanding, ack 2 cycles later -> data for 0x0006 never appears on dec; imem_addr=0x0006 until ack, then next req at 0x0100.
- HALT in the output register with dec_ready=0, then redirect_valid=1 to 0x0040 -> halted stays 0; fetch resumes at 0x0040.
- Start pc=0xFFFE via redirect -> dec_pc=0xFFFE, dec_pc_inc=0x0000, next req at 0x0000.
- rst asserted mid-request with ack arriving the same cycle -> all outputs at reset values next cycle; the acked data is dropped.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem read; result registered to decode one cycle after imem_ack.
// Sustains 1 instr/cycle with same-cycle acks; a stalled decode blocks new requests.
module fetch_unit #(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter logic [15:0] NOP_INSTR = 16'h0800
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_ack,
   input  logic [15:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [15:0] redirect_pc,
   output logic        dec_valid,
   input  logic        dec_ready,
   output logic [15:0] dec_instr,
   output logic [15:0] dec_pc,
   output logic [15:0] dec_pc_inc,
   output logic        halted
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DRAIN,
      S_HALTWAIT,
      S_HALT
   } state_t;

   state_t      state, state_nxt;
   logic [15:0] pc, pc_nxt;
   logic [15:0] addr_q, addr_nxt;
   logic        valid_q, valid_nxt;
   logic [15:0] instr_q, instr_nxt;
   logic [15:0] dpc_q, dpc_nxt;
   logic [15:0] dinc_q, dinc_nxt;
   logic        halted_q, halted_nxt;
   logic        req;
   logic [15:0] pc_plus2;
   logic        halt_op;

   assign pc_plus2 = pc + 16'd2;
   assign halt_op  = (imem_rdata[15:11] == 5'b00000);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         pc       <= RESET_PC;
         addr_q   <= RESET_PC;
         valid_q  <= 1'b0;
         instr_q  <= NOP_INSTR;
         dpc_q    <= 16'h0000;
         dinc_q   <= 16'h0000;
         halted_q <= 1'b0;
      end else begin
         state    <= state_nxt;
         pc       <= pc_nxt;
         addr_q   <= addr_nxt;
         valid_q  <= valid_nxt;
         instr_q  <= instr_nxt;
         dpc_q    <= dpc_nxt;
         dinc_q   <= dinc_nxt;
         halted_q <= halted_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      pc_nxt     = pc;
      addr_nxt   = addr_q;
      valid_nxt  = valid_q;
      instr_nxt  = instr_q;
      dpc_nxt    = dpc_q;
      dinc_nxt   = dinc_q;
      halted_nxt = halted_q;
      req        = 1'b0;

      case (state)
         S_IDLE: begin
            state_nxt = S_FETCH;
            if (redirect_valid) begin
               pc_nxt   = redirect_pc;
               addr_nxt = redirect_pc;
            end
         end

         S_FETCH: begin
            // Request only when the output register frees this cycle, so an ack always finds it empty.
            req = !valid_q || dec_ready;
            if (valid_q && dec_ready)
               valid_nxt = 1'b0;
            if (redirect_valid) begin
               valid_nxt = 1'b0;
               pc_nxt    = redirect_pc;
               if (req && !imem_ack)
                  state_nxt = S_DRAIN;
               else
                  addr_nxt = redirect_pc;
            end else if (req && imem_ack) begin
               instr_nxt = imem_rdata;
               dpc_nxt   = pc;
               dinc_nxt  = pc_plus2;
               valid_nxt = 1'b1;
               pc_nxt    = pc_plus2;
               addr_nxt  = pc_plus2;
               if (halt_op)
                  state_nxt = S_HALTWAIT;
            end
         end

         S_DRAIN: begin
            // Keep the stale request alive until memory answers; the target waits in pc.
            req       = 1'b1;
            valid_nxt = 1'b0;
            if (redirect_valid)
               pc_nxt = redirect_pc;
            if (imem_ack) begin
               addr_nxt  = redirect_valid ? redirect_pc : pc;
               state_nxt = S_FETCH;
            end
         end

         S_HALTWAIT: begin
            if (redirect_valid) begin
               valid_nxt = 1'b0;
               pc_nxt    = redirect_pc;
               addr_nxt  = redirect_pc;
               state_nxt = S_FETCH;
            end else if (dec_ready) begin
               halted_nxt = 1'b1;
               valid_nxt  = 1'b0;
               state_nxt  = S_HALT;
            end
         end

         S_HALT: begin
            state_nxt = S_HALT;
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   assign imem_req   = req;
   assign imem_addr  = addr_q;
   assign dec_valid  = valid_q;
   assign dec_instr  = valid_q ? instr_q : NOP_INSTR;
   assign dec_pc     = dpc_q;
   assign dec_pc_inc = dinc_q;
   assign halted     = halted_q;

endmodule
